// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared constants, syndrome type and syndrome helper for the (11,7) Hamming code
package hamming_pkg;

    localparam int CODE_W = 11;
    localparam int DATA_W = 7;
    localparam int SYN_W  = 4;

    typedef logic [SYN_W-1:0] syn_t;

    // Parity sits at positions 1, 2, 4 and 8; the encoder uses the same mask.
    localparam logic [CODE_W:1] PAR_MASK = 11'h08B;

    // Syndrome bit k covers every position whose index has bit k set.
    localparam logic [CODE_W:1] SYN_MASK0 = 11'h555;
    localparam logic [CODE_W:1] SYN_MASK1 = 11'h666;
    localparam logic [CODE_W:1] SYN_MASK2 = 11'h078;
    localparam logic [CODE_W:1] SYN_MASK3 = 11'h780;

    function automatic syn_t calc_syn(input logic [CODE_W:1] code);
        return {^(code & SYN_MASK3), ^(code & SYN_MASK2),
                ^(code & SYN_MASK1), ^(code & SYN_MASK0)};
    endfunction

endpackage

// File: rtl/hamming_correct.sv
// rtl/hamming_correct.sv - combinational single-bit correction and data extraction
module hamming_correct
    import hamming_pkg::*;
(
    input  logic [CODE_W:1] code,
    input  syn_t            syn,
    output logic [DATA_W:1] data,
    output logic            corr,
    output logic            uncorr
);

    localparam logic [CODE_W:1] ONE_HOT = {{(CODE_W-1){1'b0}}, 1'b1};

    logic [CODE_W:1] flip;
    logic [CODE_W:1] fixed;

    always_comb begin
        corr   = (syn != '0) && (syn <= SYN_W'(CODE_W));
        uncorr = (syn > SYN_W'(CODE_W));
        flip   = corr ? (ONE_HOT << (syn - 1'b1)) : '0;
        fixed  = code ^ flip;
        data   = {fixed[11], fixed[10], fixed[9], fixed[7], fixed[6], fixed[5], fixed[3]};
    end

endmodule

// File: rtl/hamming_dec.sv
// rtl/hamming_dec.sv - two-stage pipelined Hamming(11,7) decoder with saturating error counters
module hamming_dec
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W:1]   in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:1]   out_data,
    output logic [SYN_W-1:0]  out_syn,
    output logic              out_corr,
    output logic              out_uncorr,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    logic            s1_valid;
    logic [CODE_W:1] s1_code;
    syn_t            s1_syn;
    logic            s2_advance;
    logic            out_fire;
    logic [DATA_W:1] fix_data;
    logic            fix_corr;
    logic            fix_uncorr;

    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance;
    assign out_fire   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= in_code;
                s1_syn  <= calc_syn(in_code);
            end
        end
    end

    hamming_correct u_correct (
        .code   (s1_code),
        .syn    (s1_syn),
        .data   (fix_data),
        .corr   (fix_corr),
        .uncorr (fix_uncorr)
    );

    // Output registers only load on a new word, so they hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_syn    <= '0;
            out_corr   <= 1'b0;
            out_uncorr <= 1'b0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data   <= fix_data;
                out_syn    <= s1_syn;
                out_corr   <= fix_corr;
                out_uncorr <= fix_uncorr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (out_fire && out_corr && (corr_cnt != '1))
                corr_cnt <= corr_cnt + CNT_W'(1);
            if (out_fire && out_uncorr && (uncorr_cnt != '1))
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end

endmodule
